cu_fsm: RTL and testbench

Multicycle sequencing controller for the OTTER RV32I core. It drives the fetch/execute/writeback cadence around the combinational decoder, register file, memory and CSR file. It issues memory read/write strobes with ready handshakes, gates PC, IR, register-file and CSR writes, and takes interrupts between instructions by asserting `int_taken` into the decoder for one cycle.

---
 rtl/otter_pkg.sv | 26 ++
 rtl/cu_fsm.sv | 136 +++++++++++++
 tb/tb_cu_fsm.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: control-unit state encoding and RV32I opcodes.
// ST_INTR exists only when CU_FSM_INTR_EN is defined.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
`ifdef CU_FSM_INTR_EN
    ST_INTR  = 3'd4,
`endif
    ST_WB    = 3'd3
  } cu_state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

endpackage

// File: rtl/cu_fsm.sv
// Multicycle OTTER control unit: fetch/exec/writeback sequencing with ready handshakes.
// Interrupt entry (ST_INTR, int_taken) is built only when CU_FSM_INTR_EN is defined.
module cu_fsm
  import otter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       intr,
  input  logic       mie,
  input  logic [6:0] ir0,
  input  logic [2:0] ir12,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       reset,
  output logic       ir_ld,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       pc_write,
  output logic       reg_write,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec
);

  cu_state_t state, nxt;
  logic      commit;

`ifndef CU_FSM_INTR_EN
  logic unused_intr;
  assign unused_intr = intr ^ mie;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= nxt;
  end

  always_comb begin
    reset     = 1'b0;
    ir_ld     = 1'b0;
    mem_rden1 = 1'b0;
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    csr_we    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    commit    = 1'b0;
    nxt       = state;
    if (rst) begin
      // reset overrides everything, including a pending wait or interrupt entry
      reset = 1'b1;
      nxt   = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          reset = 1'b1;
          nxt   = ST_FETCH;
        end
        ST_FETCH: begin
          mem_rden1 = 1'b1;
          if (imem_ready) begin
            ir_ld = 1'b1;
            nxt   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ir0)
            OP_BRANCH: begin
              pc_write = 1'b1;
              commit   = 1'b1;
            end
            OP_LOAD: begin
              mem_rden2 = 1'b1;
              if (dmem_ready) nxt = ST_WB;
            end
            OP_STORE: begin
              mem_we2 = 1'b1;
              if (dmem_ready) begin
                pc_write = 1'b1;
                commit   = 1'b1;
              end
            end
            OP_SYS: begin
              pc_write = 1'b1;
              if (ir12 != 3'b000) begin
                reg_write = 1'b1;
                csr_we    = 1'b1;
                commit    = 1'b1;
              end else begin
                // mret never chains into an interrupt: one instruction runs first
                mret_exec = 1'b1;
                nxt       = ST_FETCH;
              end
            end
            OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
              reg_write = 1'b1;
              pc_write  = 1'b1;
              commit    = 1'b1;
            end
            default: begin
              // unknown opcodes decode as jal
              reg_write = 1'b1;
              pc_write  = 1'b1;
              commit    = 1'b1;
            end
          endcase
        end
        ST_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          commit    = 1'b1;
        end
`ifdef CU_FSM_INTR_EN
        ST_INTR: begin
          int_taken = 1'b1;
          pc_write  = 1'b1;
          nxt       = ST_FETCH;
        end
`endif
        default: nxt = ST_INIT;
      endcase

      if (commit) begin
`ifdef CU_FSM_INTR_EN
        nxt = (intr && mie) ? ST_INTR : ST_FETCH;
`else
        nxt = ST_FETCH;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: driver queues expected output vectors, negedge monitor compares.
// Interrupt expectations follow CU_FSM_INTR_EN.
module tb_cu_fsm;

  logic       clk = 1'b0;
  logic       rst, intr, mie, imem_ready, dmem_ready;
  logic [6:0] ir0;
  logic [2:0] ir12;
  logic       reset, ir_ld, mem_rden1, mem_rden2, mem_we2;
  logic       pc_write, reg_write, csr_we, int_taken, mret_exec;

  cu_fsm dut (
    .clk(clk), .rst(rst), .intr(intr), .mie(mie), .ir0(ir0), .ir12(ir12),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .reset(reset), .ir_ld(ir_ld), .mem_rden1(mem_rden1), .mem_rden2(mem_rden2),
    .mem_we2(mem_we2), .pc_write(pc_write), .reg_write(reg_write), .csr_we(csr_we),
    .int_taken(int_taken), .mret_exec(mret_exec)
  );

  always #5 clk = ~clk;

  // output vector bit positions
  localparam logic [9:0] RST  = 10'b1000000000;
  localparam logic [9:0] IRLD = 10'b0100000000;
  localparam logic [9:0] RD1  = 10'b0010000000;
  localparam logic [9:0] RD2  = 10'b0001000000;
  localparam logic [9:0] WE2  = 10'b0000100000;
  localparam logic [9:0] PCW  = 10'b0000010000;
  localparam logic [9:0] RW   = 10'b0000001000;
  localparam logic [9:0] CSRW = 10'b0000000100;
  localparam logic [9:0] INTK = 10'b0000000010;
  localparam logic [9:0] MRET = 10'b0000000001;

  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYS    = 7'b1110011;
  localparam logic [6:0] BOGUS  = 7'b1111111;

  typedef struct {
    logic [9:0] exp;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  wire [9:0] act = {reset, ir_ld, mem_rden1, mem_rden2, mem_we2,
                    pc_write, reg_write, csr_we, int_taken, mret_exec};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d outputs got %b want %b", e.step, act, e.exp);
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue that cycle's outputs.
  task automatic step(input logic r, input logic im, input logic dm, input logic it,
                      input logic me, input logic [6:0] op, input logic [2:0] f3,
                      input logic [9:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; imem_ready = im; dmem_ready = dm; intr = it; mie = me; ir0 = op; ir12 = f3;
    step_no++;
    x.exp = e;
    x.step = step_no;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1; intr = 1'b0; mie = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    ir0 = 7'd0; ir12 = 3'd0;

    // reset, then addi
    step(1, 1, 1, 0, 0, ADDI, 0, RST);
    step(0, 1, 1, 0, 0, ADDI, 0, RST);
    step(0, 1, 1, 0, 0, ADDI, 0, RD1 | IRLD);
    step(0, 1, 1, 0, 0, ADDI, 0, RW | PCW);
    // load with three stalled cycles
    step(0, 1, 0, 0, 0, LOAD, 0, RD1 | IRLD);
    step(0, 1, 0, 0, 0, LOAD, 0, RD2);
    step(0, 1, 0, 0, 0, LOAD, 0, RD2);
    step(0, 1, 0, 0, 0, LOAD, 0, RD2);
    step(0, 1, 1, 0, 0, LOAD, 0, RD2);
    step(0, 1, 1, 0, 0, LOAD, 0, RW | PCW);
    // instruction fetch stall, then store with one stall
    step(0, 0, 1, 0, 0, STORE, 0, RD1);
    step(0, 1, 1, 0, 0, STORE, 0, RD1 | IRLD);
    step(0, 1, 0, 0, 0, STORE, 0, WE2);
    step(0, 1, 1, 0, 0, STORE, 0, WE2 | PCW);
    // branch commit with interrupt pending and enabled
    step(0, 1, 1, 1, 1, BRANCH, 0, RD1 | IRLD);
    step(0, 1, 1, 1, 1, BRANCH, 0, PCW);
`ifdef CU_FSM_INTR_EN
    step(0, 1, 1, 1, 1, BRANCH, 0, INTK | PCW);
`endif
    // branch with interrupt masked
    step(0, 1, 1, 1, 0, BRANCH, 0, RD1 | IRLD);
    step(0, 1, 1, 1, 0, BRANCH, 0, PCW);
    // mret ignores intr; the following addi takes it
    step(0, 1, 1, 1, 1, SYS, 0, RD1 | IRLD);
    step(0, 1, 1, 1, 1, SYS, 0, MRET | PCW);
    step(0, 1, 1, 1, 1, ADDI, 0, RD1 | IRLD);
    step(0, 1, 1, 1, 1, ADDI, 0, RW | PCW);
`ifdef CU_FSM_INTR_EN
    step(0, 1, 1, 0, 0, ADDI, 0, INTK | PCW);
`endif
    // CSR instruction
    step(0, 1, 1, 0, 0, SYS, 3'b001, RD1 | IRLD);
    step(0, 1, 1, 0, 0, SYS, 3'b001, RW | CSRW | PCW);
    // unrecognised opcode behaves like jal; dmem_ready ignored outside load/store
    step(0, 1, 0, 0, 0, BOGUS, 0, RD1 | IRLD);
    step(0, 1, 0, 0, 0, BOGUS, 0, RW | PCW);
    // rst during a stalled fetch
    step(0, 0, 0, 0, 0, ADDI, 0, RD1);
    step(1, 0, 0, 0, 0, ADDI, 0, RST);
    step(0, 1, 0, 0, 0, ADDI, 0, RST);
    step(0, 1, 0, 0, 0, ADDI, 0, RD1 | IRLD);
    step(0, 1, 0, 0, 0, ADDI, 0, RW | PCW);
    // rst during a stalled load, with ready arriving the same cycle
    step(0, 1, 0, 0, 0, LOAD, 0, RD1 | IRLD);
    step(0, 1, 0, 0, 0, LOAD, 0, RD2);
    step(1, 1, 1, 0, 0, LOAD, 0, RST);
    step(0, 1, 1, 0, 0, LOAD, 0, RST);
    step(0, 1, 1, 0, 0, LOAD, 0, RD1 | IRLD);
`ifdef CU_FSM_INTR_EN
    // rst beats an interrupt entry
    step(0, 1, 1, 1, 1, BRANCH, 0, PCW);
    step(1, 1, 1, 1, 1, BRANCH, 0, RST);
    step(0, 1, 1, 0, 0, BRANCH, 0, RST);
    step(0, 1, 1, 0, 0, BRANCH, 0, RD1 | IRLD);
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
